// File: rtl/muxn_arb_reg.sv
// muxn_arb_reg: N-channel select or round-robin mux feeding a single-entry registered output stage.
module muxn_arb_reg #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  parameter int MODE = 0,
  localparam int SW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0] src_q, src_d, rr_q, rr_d, rr_idx, gidx;
  logic valid_q, valid_d, open, found, xfer;
  // Two passes: channels at or above rr_q first, then the wrapped-around ones.
  always_comb begin
    found = 1'b0;
    rr_idx = '0;
    for (int k = 0; k < N; k++)
      if (!found && in_valid[k] && SW'(k) >= rr_q) begin
        found = 1'b1;
        rr_idx = SW'(k);
      end
    for (int k = 0; k < N; k++)
      if (!found && in_valid[k]) begin
        found = 1'b1;
        rr_idx = SW'(k);
      end
  end
  always_comb begin
    open = !valid_q || out_ready;
    gidx = MODE == 0 ? sel : rr_idx;
    in_ready = '0;
    data_d = data_q;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = open && !reset && (MODE == 0 ? sel == SW'(k) : found && rr_idx == SW'(k));
      if (in_ready[k] && in_valid[k]) data_d = in_data[k*WIDTH +: WIDTH];
    end
    xfer = |(in_ready & in_valid);
    src_d = xfer ? gidx : src_q;
    valid_d = xfer || (valid_q && !out_ready);
    rr_d = (MODE == 1 && xfer) ? (gidx == SW'(N-1) ? '0 : gidx + SW'(1)) : rr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      src_q <= '0;
      valid_q <= 1'b0;
      rr_q <= '0;
    end else begin
      data_q <= data_d;
      src_q <= src_d;
      valid_q <= valid_d;
      rr_q <= rr_d;
    end
  end
  assign out_data = data_q;
  assign out_src = src_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_muxn_arb_reg.sv
// tb_muxn_arb_reg: scoreboard bench over three configurations (select N=4, round-robin N=4, select N=3).
module tb_muxn_arb_reg;
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } item_t;
  logic clk, reset;
  logic [3:0] iv[3];
  logic [1:0] sel[3];
  logic ordy[3];
  logic [31:0] dat[3][4];
  logic [3:0] ir0, ir1;
  logic [2:0] ir2;
  logic [31:0] od0, od1, od2;
  logic [1:0] os0, os1, os2;
  logic ov0, ov1, ov2;
  logic [3:0] ir[3];
  logic [31:0] od[3];
  logic [1:0] os[3];
  logic ov[3];
  int errors = 0, checks = 0;
  item_t q0[$], q1[$], q2[$];
  bit mvalid[3];
  int mptr[3];
  int m_n, m_iv, m_exp, m_g;
  bit m_open;
  item_t mon_it;

  muxn_arb_reg #(.WIDTH(32), .N(4), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_data({dat[0][3], dat[0][2], dat[0][1], dat[0][0]}),
    .in_valid(iv[0]), .in_ready(ir0), .sel(sel[0]), .out_data(od0), .out_src(os0),
    .out_valid(ov0), .out_ready(ordy[0]));
  muxn_arb_reg #(.WIDTH(32), .N(4), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_data({dat[1][3], dat[1][2], dat[1][1], dat[1][0]}),
    .in_valid(iv[1]), .in_ready(ir1), .sel(sel[1]), .out_data(od1), .out_src(os1),
    .out_valid(ov1), .out_ready(ordy[1]));
  muxn_arb_reg #(.WIDTH(32), .N(3), .MODE(0)) u2 (
    .clk(clk), .reset(reset), .in_data({dat[2][2], dat[2][1], dat[2][0]}),
    .in_valid(iv[2][2:0]), .in_ready(ir2), .sel(sel[2]), .out_data(od2), .out_src(os2),
    .out_valid(ov2), .out_ready(ordy[2]));

  always_comb begin
    ir[0] = ir0;
    ir[1] = ir1;
    ir[2] = {1'b0, ir2};
    od[0] = od0;
    od[1] = od1;
    od[2] = od2;
    os[0] = os0;
    os[1] = os1;
    os[2] = os2;
    ov[0] = ov0;
    ov[1] = ov1;
    ov[2] = ov2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic int nof(int k);
    return k == 2 ? 3 : 4;
  endfunction

  function automatic void push(int k, item_t it);
    case (k)
      0: q0.push_back(it);
      1: q1.push_back(it);
      default: q2.push_back(it);
    endcase
  endfunction

  function automatic int qsize(int k);
    return k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
  endfunction

  function automatic item_t pop(int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Reference model: decides each channel's grant from the rules, one step ahead of the edge.
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        chk($sformatf("reset in_ready[%0d]", k), 32'(ir[k]), 0);
        mvalid[k] = 0;
        mptr[k] = 0;
        case (k)
          0: q0.delete();
          1: q1.delete();
          default: q2.delete();
        endcase
      end else begin
        m_n = nof(k);
        m_iv = int'(iv[k]) & ((1 << m_n) - 1);
        m_open = !mvalid[k] || ordy[k];
        m_g = -1;
        if (m_open) begin
          if (k != 1) m_g = int'(sel[k]) < m_n ? int'(sel[k]) : -1;
          else
            for (int j = 0; j < m_n; j++)
              if (m_g < 0 && ((m_iv >> ((mptr[k] + j) % m_n)) & 1) == 1) m_g = (mptr[k] + j) % m_n;
        end
        m_exp = m_g < 0 ? 0 : 1 << m_g;
        chk($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(m_exp));
        if ((m_exp & m_iv) != 0) begin
          push(k, '{d: dat[k][m_g], s: 2'(m_g)});
          mvalid[k] = 1;
          if (k == 1) mptr[k] = (m_g + 1) % m_n;
        end else if (ordy[k]) mvalid[k] = 0;
      end
    end
  end

  // Monitor: every output handshake retires the oldest expected word.
  always @(negedge clk) begin
    if (!reset)
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(mvalid[k]));
        if (ov[k] && ordy[k]) begin
          if (qsize(k) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected word[%0d]: got %h expected none", k, od[k]);
          end else begin
            mon_it = pop(k);
            chk($sformatf("out_data[%0d]", k), od[k], mon_it.d);
            chk($sformatf("out_src[%0d]", k), 32'(os[k]), 32'(mon_it.s));
          end
        end
      end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 4'hF;
      sel[k] = '0;
      ordy[k] = 1'b1;
      for (int c = 0; c < 4; c++) dat[k][c] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(ov0), 0);
    chk("rst out_data", od0, 0);
    chk("rst out_src", 32'(os0), 0);
    chk("rst in_ready", 32'(ir0), 0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) iv[k] = '0;
    sel[0] = 2'd2;
    iv[0] = 4'b0100;
    dat[0][2] = 32'hA5A5A5A5;
    @(negedge clk);
    chk("sel in_ready", 32'(ir0), 32'b0100);
    cyc();
    ordy[0] = 1'b0;
    dat[0][2] = 32'h11111111;
    @(negedge clk);
    chk("load data", od0, 32'hA5A5A5A5);
    chk("load src", 32'(os0), 2);
    repeat (3) begin
      cyc();
      @(negedge clk);
      chk("bp in_ready", 32'(ir0), 0);
      chk("bp data", od0, 32'hA5A5A5A5);
      chk("bp src", 32'(os0), 2);
    end
    cyc();
    ordy[0] = 1'b1;
    dat[0][2] = 32'h22222222;
    cyc();
    iv[0] = '0;
    @(negedge clk);
    chk("b2b valid", 32'(ov0), 1);
    chk("b2b data", od0, 32'h22222222);
    cyc();
    iv[1] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc();
      @(negedge clk);
      chk("rr valid", 32'(ov1), 1);
      chk("rr src", 32'(os1), 32'(i % 4));
    end
    cyc();
    iv[1] = 4'b0010;
    @(negedge clk);
    chk("wrap in_ready", 32'(ir1), 32'b0010);
    cyc();
    iv[1] = 4'hF;
    @(negedge clk);
    chk("wrap src", 32'(os1), 1);
    chk("wrap next grant", 32'(ir1), 32'b0100);
    cyc();
    iv[1] = '0;
    cyc();
    sel[2] = 2'd3;
    iv[2] = 4'b0111;
    repeat (3) begin
      @(negedge clk);
      chk("badsel in_ready", 32'(ir2), 0);
      chk("badsel valid", 32'(ov2), 0);
      cyc();
    end
    iv[2] = '0;
    sel[0] = 2'd1;
    iv[0] = 4'b0010;
    ordy[0] = 1'b0;
    dat[0][1] = 32'hDEADBEEF;
    cyc();
    iv[0] = '0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst drop valid", 32'(ov0), 0);
    for (int c = 0; c < 400; c++) begin
      cyc();
      for (int k = 0; k < 3; k++) begin
        iv[k] = 4'($urandom);
        sel[k] = 2'($urandom);
        ordy[k] = $urandom_range(0, 3) != 0;
        for (int ch = 0; ch < 4; ch++) dat[k][ch] = $urandom;
      end
    end
    cyc();
    for (int k = 0; k < 3; k++) begin
      iv[k] = '0;
      ordy[k] = 1'b1;
    end
    repeat (3) cyc();
    @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) chk($sformatf("drain q[%0d]", k), 32'(qsize(k)), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muxn_arb_reg.md
MUXN_ARB_REG -- requirements
Module: muxn_arb_reg

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width per channel (1..64).
REQ-002 The block SHALL have parameter N, default 4, meaning number of input channels (2..8).
REQ-003 The block SHALL have parameter MODE, default 0, meaning 0 = select-driven, 1 = round-robin arbitration.
REQ-004 The block SHALL have localparam SW = clog2(N), meaning select and source-index width.

Ports:
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port in_data, input, N*WIDTH bits, channel i occupying bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port in_valid, input, N bits, per-channel valid.
REQ-009 The block SHALL have port in_ready, output, N bits, per-channel accept; at most one bit is high per cycle.
REQ-010 The block SHALL have port sel, input, SW bits, channel select, used only when MODE=0.
REQ-011 The block SHALL have port out_data, output, WIDTH bits, registered selected data.
REQ-012 The block SHALL have port out_src, output, SW bits, index of the channel that supplied out_data.
REQ-013 The block SHALL have port out_valid, output, 1 bit, output register holds data.
REQ-014 The block SHALL have port out_ready, input, 1 bit, downstream accept.

Function
REQ-015 The output register SHALL be "open" in a cycle when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-016 A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both 1; out_data, out_src and out_valid=1 SHALL be loaded on the next rising edge (latency 1 cycle).
REQ-017 When MODE=0, in_ready[sel] SHALL be 1 exactly when the register is open and sel < N; all other in_ready bits SHALL be 0.
REQ-018 When MODE=0 and sel >= N (N not a power of 2), no channel SHALL be granted and in_ready SHALL be all 0.
REQ-019 When MODE=1, the grant SHALL go to the first channel with in_valid=1, searching from rr_ptr upward and wrapping modulo N; it is gated by the open condition.
REQ-020 When MODE=1, rr_ptr SHALL become (granted index + 1) mod N after each transfer and SHALL be unchanged in cycles with no transfer.
REQ-021 When MODE=1 and rr_ptr = N-1, the wrap SHALL return rr_ptr to 0.
REQ-022 A simultaneous drain (out_valid & out_ready) and load SHALL replace the register contents with the new channel data, with out_valid staying 1 and no bubble.
REQ-023 A drain with no load SHALL set out_valid to 0; out_data and out_src SHALL then hold their last values.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_src SHALL be stable and in_ready SHALL be all 0.
REQ-025 in_ready SHALL be combinational from in_valid, sel, out_valid, out_ready and rr_ptr; there SHALL be no combinational path from in_data to any output.

Reset
REQ-026 When reset=1 at a rising edge, out_valid SHALL be 0, out_data SHALL be 0, out_src SHALL be 0 and rr_ptr SHALL be 0.
REQ-027 While reset=1, in_ready SHALL be all 0.
REQ-028 A reset asserted while out_valid=1 SHALL discard the held word without a handshake.

Verification
REQ-029 Reset check: MODE=0, N=4. Assert reset with all in_valid=1 and out_ready=1. Required response: out_valid=0, out_data=0, in_ready=0000.
REQ-030 Select path: MODE=0, sel=2, in_valid=0100, ch2 data=0xA5A5A5A5, out_ready=1. Required response: in_ready=0100; next cycle out_data=0xA5A5A5A5 and out_src=2.
REQ-031 Backpressure: hold out_ready=0 after the load in REQ-030. Required response: in_ready=0000 and out_data stable; when out_ready=1 with a new ch2 word, the register reloads back-to-back with out_valid staying 1.
REQ-032 Round-robin fairness: MODE=1, N=4, in_valid=1111 continuously, out_ready=1. Required response: out_src sequence 0,1,2,3,0,1, one word per cycle.
REQ-033 Sparse wrap: MODE=1, rr_ptr=3, in_valid=0010. Required response: ch1 is granted and rr_ptr becomes 2.
REQ-034 Invalid select: MODE=0, N=3, sel=3, in_valid=111. Required response: in_ready=000 and out_valid stays 0.
